laser_enable_sequencer: RTL and testbench
=========================================

# laser_enable_sequencer

Sequences laser power-up, steady operation and shutdown for the safety FPGA. It sits between the I2C register file (enable request, clear, watchdog kick) and the limit-check / peak-power checkers (fault flags). It drives the laser power enable and TA shutdown outputs. Every fault latches its cause and forces the laser off until the host explicitly clears it.

## Interface
Parameters:
- SETTLE_CYCLES, 25000: cycles between power enable and TA release (1 ms at clk_div2); legal range 1..2^24-1.
- COOLDOWN_CYCLES, 12500: cycles power stays on after TA shutdown on a normal disable; legal range 1..2^24-1.
- WDOG_CYCLES, 2500000: maximum cycles between host kicks while ACTIVE (100 ms); legal range 1..2^24-1.

Ports:
- clk  in  1  system clock (clk_div2 domain). One clock; reset is asynchronous and active-low.
- rstn  in  1  asynchronous active-low reset.
- enable_req  in  1  level from static control: host wants the laser on.
- pwr_good  in  1  supply good, already synchronous.
- laser_ready  in  1  post-reset holdoff complete.
- fault_in  in  4  [0] pulse_lower, [1] pulse_upper, [2] rate, [3] peak-current fail flags.
- clear_fail  in  1  single-cycle clear pulse from dynamic control.
- wdog_kick  in  1  single-cycle host kick pulse.
- laser_pwr_en_n  out  1  active-low laser power enable.
- ta_shutdown  out  1  active-high TA shutdown.
- fault_cause  out  6  sticky cause bits: fault_in[3:0], [4] pwr_good loss, [5] watchdog.
- seq_state  out  3  current state code, for the status register.

## Operation
- States and codes: IDLE=0, SETTLE=1, ACTIVE=2, RAMPDOWN=3, FAULT=4. All outputs are registered decodes of state.
- Outputs by state:
  - IDLE: en_n=1, ta=1.
  - SETTLE: en_n=0, ta=1.
  - ACTIVE: en_n=0, ta=0.
  - RAMPDOWN: en_n=0, ta=1.
  - FAULT: en_n=1, ta=1.
- IDLE -> SETTLE: enable_req & pwr_good & laser_ready & fault_in==0. A fault in IDLE blocks arming but is not latched.
- SETTLE: a 24-bit counter loads SETTLE_CYCLES-1 on entry and goes to ACTIVE when it reaches 0.
- ACTIVE: the watchdog counter loads WDOG_CYCLES-1 on entry and reloads on each wdog_kick. On reaching 0 with no kick in that cycle, go to FAULT and set cause[5].
- SETTLE/ACTIVE with enable_req=0 -> RAMPDOWN. The counter loads COOLDOWN_CYCLES-1; at 0 go to IDLE.
- Fault entry from SETTLE, ACTIVE or RAMPDOWN is triggered by any fault_in bit or by pwr_good=0. The corresponding bits are ORed into fault_cause; all causes present in the entry cycle are recorded.
- Priority in one cycle: fault_in/pwr_good loss > watchdog expiry > enable_req drop > counter expiry.
- A kick arriving in the same cycle as watchdog expiry wins: reload, no fault.
- FAULT -> IDLE only when clear_fail=1 & fault_in==0 & enable_req==0. fault_cause clears on that transition. Otherwise clear_fail is ignored and causes stay latched.
- Exiting FAULT requires enable_req to be deasserted, so the laser cannot re-arm automatically.

## Timing
- Reset: state IDLE, laser_pwr_en_n=1, ta_shutdown=1, fault_cause=0, seq_state=0, counter=0.
- Fault latency: fault_in sampled high at edge n gives en_n=1, ta=1 and fault_cause updated after edge n (1 cycle).
- Arm: request seen at edge n gives en_n=0 after n. ta falls after edge n+SETTLE_CYCLES.
- Disable: enable_req low at edge m gives ta=1 after m. en_n rises after edge m+COOLDOWN_CYCLES.
- Watchdog: with no kick, FAULT is entered at edge ACTIVE-entry+WDOG_CYCLES.
- enable_req toggling inside RAMPDOWN has no effect; the cooldown always completes.

## Structure
- Package laser_seq_pkg holds:
  - state encodings;
  - fault_cause bit indices;
  - counter width (24).
- One sub-module, seq_timer: a loadable 24-bit down-counter with load/value/zero. It is shared by SETTLE, RAMPDOWN and ACTIVE; in ACTIVE it serves as the watchdog.
- The FSM stays in the top of the block.

## Test plan
Bench parameters: SETTLE=4, COOLDOWN=3, WDOG=10.
- Normal cycle: raise enable_req with pwr_good=laser_ready=1 -> en_n falls after 1 cycle, ta falls 4 cycles later. Kick every 5 cycles: stays ACTIVE. Drop enable_req -> ta=1 next cycle, en_n=1 three cycles later, seq_state=0.
- Fault in ACTIVE: pulse fault_in=4'b0100 for 1 cycle -> en_n=1, ta=1 next cycle, fault_cause=6'b000100. A clear while enable_req=1 is ignored; drop enable_req, then clear -> IDLE, fault_cause=0.
- Watchdog: no kicks in ACTIVE -> FAULT exactly 10 cycles after entry, fault_cause=6'b100000. A kick on cycle 10 instead keeps ACTIVE.
- Simultaneous events: pwr_good low plus fault_in[3] in the same cycle as enable_req drop -> FAULT, not RAMPDOWN, fault_cause=6'b011000.
- Blocking and reset: fault_in[0]=1 in IDLE with enable_req=1 -> stays IDLE, fault_cause=0. Assert rstn low mid-SETTLE -> outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/laser_seq_pkg.sv
// Shared encodings for the laser enable sequencer.
// State codes, fault cause bit positions and counter width.
package laser_seq_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_RAMPDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } seq_state_t;

    localparam int CAUSE_W    = 6;
    localparam int CAUSE_PWR  = 4;
    localparam int CAUSE_WDOG = 5;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by settle, cooldown and watchdog timing.
// Holds at zero until reloaded.
module seq_timer
    import laser_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/laser_enable_sequencer.sv
// Laser power-up / shutdown sequencer with latched fault causes.
// Outputs are registered decodes of the next state.
module laser_enable_sequencer
    import laser_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 25000,
    parameter int unsigned COOLDOWN_CYCLES = 12500,
    parameter int unsigned WDOG_CYCLES     = 2500000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable_req,
    input  logic               pwr_good,
    input  logic               laser_ready,
    input  logic [3:0]         fault_in,
    input  logic               clear_fail,
    input  logic               wdog_kick,
    output logic               laser_pwr_en_n,
    output logic               ta_shutdown,
    output logic [CAUSE_W-1:0] fault_cause,
    output logic [2:0]         seq_state
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LD   = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LD   = CNT_W'(WDOG_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic               r_en_n;
    logic               r_ta;
    logic [CAUSE_W-1:0] r_cause;
    logic [CAUSE_W-1:0] w_cause_nxt;
    logic               w_en_n_nxt;
    logic               w_ta_nxt;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_zero;
    logic               w_fault_hit;
    logic [CAUSE_W-1:0] w_hit_bits;

    seq_timer u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_value   (w_cnt),
        .o_zero    (w_zero)
    );

    assign w_fault_hit = (|fault_in) | ~pwr_good;
    assign w_hit_bits  = {1'b0, ~pwr_good, fault_in};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_en_n  <= 1'b1;
            r_ta    <= 1'b1;
            r_cause <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en_n  <= w_en_n_nxt;
            r_ta    <= w_ta_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Fault > watchdog > enable drop > counter expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_load      = 1'b0;
        w_load_val  = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable_req && pwr_good && laser_ready
                    && (fault_in == 4'b0)) begin
                    w_state_nxt = ST_SETTLE;
                    w_load      = 1'b1;
                    w_load_val  = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (w_fault_hit) begin
                    w_state_nxt = ST_FAULT;
                    w_cause_nxt = r_cause | w_hit_bits;
                end else if (!enable_req) begin
                    w_state_nxt = ST_RAMPDOWN;
                    w_load      = 1'b1;
                    w_load_val  = COOL_LD;
                end else if (w_zero) begin
                    w_state_nxt = ST_ACTIVE;
                    w_load      = 1'b1;
                    w_load_val  = WDOG_LD;
                end
            end
            ST_ACTIVE: begin
                if (w_fault_hit) begin
                    w_state_nxt = ST_FAULT;
                    w_cause_nxt = r_cause | w_hit_bits;
                end else if (w_zero && !wdog_kick) begin
                    w_state_nxt = ST_FAULT;
                    w_cause_nxt = r_cause;
                    w_cause_nxt[CAUSE_WDOG] = 1'b1;
                end else if (!enable_req) begin
                    w_state_nxt = ST_RAMPDOWN;
                    w_load      = 1'b1;
                    w_load_val  = COOL_LD;
                end else if (wdog_kick) begin
                    w_load      = 1'b1;
                    w_load_val  = WDOG_LD;
                end
            end
            ST_RAMPDOWN: begin
                if (w_fault_hit) begin
                    w_state_nxt = ST_FAULT;
                    w_cause_nxt = r_cause | w_hit_bits;
                end else if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (clear_fail && (fault_in == 4'b0) && !enable_req) begin
                    w_state_nxt = ST_IDLE;
                    w_cause_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_en_n_nxt = 1'b1;
        w_ta_nxt   = 1'b1;
        unique case (w_state_nxt)
            ST_SETTLE:   w_en_n_nxt = 1'b0;
            ST_ACTIVE: begin
                w_en_n_nxt = 1'b0;
                w_ta_nxt   = 1'b0;
            end
            ST_RAMPDOWN: w_en_n_nxt = 1'b0;
            default: begin
                w_en_n_nxt = 1'b1;
                w_ta_nxt   = 1'b1;
            end
        endcase
    end

    assign laser_pwr_en_n = r_en_n;
    assign ta_shutdown    = r_ta;
    assign fault_cause    = r_cause;
    assign seq_state      = r_state;

    logic w_unused;
    assign w_unused = ^w_cnt;

endmodule

// File: tb/tb_laser_enable_sequencer.sv
// Directed bench for laser_enable_sequencer.
// SETTLE=4, COOLDOWN=3, WDOG=10.
module tb_laser_enable_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable_req;
    logic       pwr_good;
    logic       laser_ready;
    logic [3:0] fault_in;
    logic       clear_fail;
    logic       wdog_kick;
    logic       laser_pwr_en_n;
    logic       ta_shutdown;
    logic [5:0] fault_cause;
    logic [2:0] seq_state;

    int n_chk  = 0;
    int n_pass = 0;

    laser_enable_sequencer #(
        .SETTLE_CYCLES  (4),
        .COOLDOWN_CYCLES(3),
        .WDOG_CYCLES    (10)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable_req    (enable_req),
        .pwr_good      (pwr_good),
        .laser_ready   (laser_ready),
        .fault_in      (fault_in),
        .clear_fail    (clear_fail),
        .wdog_kick     (wdog_kick),
        .laser_pwr_en_n(laser_pwr_en_n),
        .ta_shutdown   (ta_shutdown),
        .fault_cause   (fault_cause),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic outs(input string tag, input logic [2:0] st,
                        input logic en_n, input logic ta,
                        input logic [5:0] cause);
        chk({tag, ".state"}, 32'(seq_state), 32'(st));
        chk({tag, ".en_n"}, 32'(laser_pwr_en_n), 32'(en_n));
        chk({tag, ".ta"}, 32'(ta_shutdown), 32'(ta));
        chk({tag, ".cause"}, 32'(fault_cause), 32'(cause));
    endtask

    task automatic pulse_clear();
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn        = 1'b0;
        enable_req  = 1'b0;
        pwr_good    = 1'b1;
        laser_ready = 1'b1;
        fault_in    = 4'b0;
        clear_fail  = 1'b0;
        wdog_kick   = 1'b0;
        #23;
        outs("reset", 3'd0, 1'b1, 1'b1, 6'h00);
        rstn = 1'b1;
        tick(2);
        outs("idle", 3'd0, 1'b1, 1'b1, 6'h00);

        // normal cycle
        enable_req = 1'b1;
        tick();
        outs("arm", 3'd1, 1'b0, 1'b1, 6'h00);
        tick(3);
        outs("settle3", 3'd1, 1'b0, 1'b1, 6'h00);
        tick();
        outs("active", 3'd2, 1'b0, 1'b0, 6'h00);
        for (int k = 0; k < 3; k++) begin
            tick(4);
            wdog_kick = 1'b1;
            tick();
            wdog_kick = 1'b0;
        end
        outs("kicked", 3'd2, 1'b0, 1'b0, 6'h00);
        enable_req = 1'b0;
        tick();
        outs("ramp1", 3'd3, 1'b0, 1'b1, 6'h00);
        enable_req = 1'b1;
        tick();
        enable_req = 1'b0;
        tick();
        outs("ramp3", 3'd3, 1'b0, 1'b1, 6'h00);
        tick();
        outs("ramp_done", 3'd0, 1'b1, 1'b1, 6'h00);

        // fault in ACTIVE
        enable_req = 1'b1;
        tick(5);
        chk("f.active", 32'(seq_state), 32'd2);
        fault_in = 4'b0100;
        tick();
        fault_in = 4'b0000;
        outs("fault", 3'd4, 1'b1, 1'b1, 6'b000100);
        pulse_clear();
        outs("clr_ign", 3'd4, 1'b1, 1'b1, 6'b000100);
        enable_req = 1'b0;
        tick();
        chk("f.hold", 32'(seq_state), 32'd4);
        pulse_clear();
        outs("cleared", 3'd0, 1'b1, 1'b1, 6'h00);

        // watchdog expiry
        enable_req = 1'b1;
        tick(5);
        chk("w.active", 32'(seq_state), 32'd2);
        tick(9);
        chk("w.cyc9", 32'(seq_state), 32'd2);
        tick();
        outs("wdog", 3'd4, 1'b1, 1'b1, 6'b100000);
        enable_req = 1'b0;
        pulse_clear();
        chk("w.clear", 32'(seq_state), 32'd0);

        // kick on the expiry cycle
        enable_req = 1'b1;
        tick(5);
        tick(9);
        wdog_kick = 1'b1;
        tick();
        wdog_kick = 1'b0;
        outs("k10", 3'd2, 1'b0, 1'b0, 6'h00);
        tick(9);
        chk("k10.hold", 32'(seq_state), 32'd2);

        // simultaneous pwr loss, fault[3], enable drop
        pwr_good   = 1'b0;
        fault_in   = 4'b1000;
        enable_req = 1'b0;
        tick();
        pwr_good = 1'b1;
        fault_in = 4'b0000;
        outs("simul", 3'd4, 1'b1, 1'b1, 6'b011000);
        pulse_clear();
        chk("s.clear", 32'(seq_state), 32'd0);

        // arming blocked by fault in IDLE
        fault_in   = 4'b0001;
        enable_req = 1'b1;
        tick(2);
        outs("blocked", 3'd0, 1'b1, 1'b1, 6'h00);
        fault_in = 4'b0000;
        tick(2);
        chk("b.settle", 32'(seq_state), 32'd1);

        // async reset mid-SETTLE
        #2;
        rstn = 1'b0;
        #1;
        outs("async", 3'd0, 1'b1, 1'b1, 6'h00);
        #10;
        rstn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
